jam_host: RTL
=============

# jam_host

Host-side front end for the JAM job-assignment core. It accepts an 8×8 cost table as a stream of 64 seven-bit beats and stores it in a register file. It serves the table combinationally to JAM's `W`/`J`/`Cost` lookup port and sequences JAM's reset. When JAM raises `Valid`, it captures the result with a run-cycle count and presents it on a ready/valid result port, then returns to accept the next table.

## Interface
- `COST_W`, default 7: cost entry width; must match JAM `Cost`.
- `CYC_W`, default 24: width of the run-cycle counter.
- `TIMEOUT`, default 0: maximum RUN cycles before abort; 0 disables the timeout.

- `CLK`  in  1  clock
- `RST_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  table beat valid
- `in_ready`  out  1  table beat accepted when `in_valid & in_ready`
- `in_data`  in  COST_W  cost beat, row-major: beat k is `cost[k/8][k%8]`
- `in_last`  in  1  must be high on beat 63 only
- `jam_rst`  out  1  active-high reset driven to JAM `RST`
- `W`, `J`  in  3 each  JAM worker/job select
- `Cost`  out  COST_W  `mem[{W,J}]`, combinational
- `MatchCount`  in  4  from JAM
- `MinCost`  in  10  from JAM
- `Valid`  in  1  from JAM
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid & res_ready`
- `res_min_cost`  out  10  captured result
- `res_match_count`  out  4  captured result
- `res_cycles`  out  CYC_W  captured run length
- `res_load_err`  out  1  `in_last` framing error during the preceding load
- `res_timeout`  out  1  run aborted by `TIMEOUT`

## Operation
- **FSM states.** LOAD → RUN → RES → LOAD.
- **Registered outputs.** Every output is registered except `Cost`.
- **Reset (`RST_n` low).** State = LOAD, write address = 0, `in_ready` = 0, `jam_rst` = 1, `res_valid` = 0, all `res_*` = 0, error flag = 0. Table contents are not reset.
- **LOAD.**
  - `in_ready` = 1 starting one edge after reset release or entry to LOAD.
  - Each accepted beat writes `mem[addr]` and increments the 6-bit `addr`.
  - The edge that accepts beat 63 clears `in_ready`, wraps `addr` to 0, and enters RUN.
- **Framing check.** `in_last` high on a beat other than 63, or low on beat 63, sets the sticky load-error flag. Loading always continues to exactly 64 beats.
- **Entry to RUN.**
  - `jam_rst` deasserts on the entry edge.
  - The cycle counter loads 1, so the first RUN cycle counts as 1.
- **RUN.**
  - The counter increments each cycle and saturates at all-ones.
  - `Valid` is sampled only in RUN.
  - On the first cycle with `Valid` = 1, the next edge captures `MinCost`, `MatchCount`, the counter value (the count includes the `Valid` cycle), the error flag, and `res_timeout` = 0. The same edge sets `res_valid` = 1, sets `jam_rst` = 1, and enters RES.
- **Timeout.** If `TIMEOUT` ≠ 0 and the counter equals `TIMEOUT` with `Valid` low, the next edge enters RES with `res_timeout` = 1, `res_min_cost` = 10'h3FF, `res_match_count` = 0, and `res_cycles` = `TIMEOUT`.
- **RES.**
  - `res_*` hold stable while `res_ready` = 0.
  - On handshake: `res_valid` clears, the error flag clears, and the FSM enters LOAD. `in_ready` rises on the following edge.
- **Ignored inputs.**
  - `in_valid` outside LOAD is ignored.
  - `Valid` in LOAD or RES is ignored, since JAM is held in reset there.
- **Cost lookup.** `Cost` is valid in every state. A write and a read of the same address in the same cycle return the old value.

## Timing
- **Load.** 64 accepted beats. With continuous `in_valid`, the path from the first `in_ready` = 1 cycle to `jam_rst` = 0 is 64 edges.
- **Result capture.** `Valid` high at RUN cycle N gives `res_valid` = 1 one edge later, with `res_cycles` = N.
- **Handshake to next load.** `res_valid & res_ready` at an edge, then `in_ready` = 1 one edge later.
- **JAM reset hold.** `jam_rst` is high for at least 65 cycles before every RUN.
- **Reset mid-operation.** Asynchronous assertion forces all outputs to their reset values immediately, including `jam_rst` = 1. Any partial load is discarded, and the next load starts at beat 0.

## Test plan
- **Load and lookup.** Load `cost[w][j] = (8w+j)%100` continuously, with `in_last` on beat 63. Then `W=3`, `J=5` → `Cost` = 29, and `W=7`, `J=7` → `Cost` = 63. `in_ready` falls after beat 63, and `jam_rst` falls on the same edge.
- **Input backpressure.** Same table with random `in_valid` gaps → identical lookups, and the beat count is still exactly 64.
- **Result capture and hold.** A JAM stub raises `Valid` at RUN cycle 40 with `MinCost` = 312, `MatchCount` = 3 → `res_valid` = 1, with `res_min_cost` = 312, `res_match_count` = 3, `res_cycles` = 40. Hold `res_ready` low for 5 cycles: all outputs stay stable. After the handshake, `in_ready` = 1 one cycle later and `jam_rst` = 1.
- **Framing error.** Raise `in_last` on beat 10 → the run completes normally with `res_load_err` = 1. The next clean load gives `res_load_err` = 0.
- **Timeout.** `TIMEOUT` = 100 and the stub never asserts `Valid` → `res_valid` at RUN cycle 101, with `res_timeout` = 1, `res_min_cost` = 1023, `res_match_count` = 0, `res_cycles` = 100.
- **Reset mid-run.** Drop `RST_n` in RUN cycle 20 → immediately `jam_rst` = 1, `res_valid` = 0, `in_ready` = 0. After release, a full 64-beat reload is required before RUN.

Source files
------------

// File: rtl/jam_host_if.sv
// Signal bundle between jam_host, its table/result host and the JAM core.
// The slave modport is the jam_host side; master is the environment side.
interface jam_host_if #(
    parameter int unsigned COST_W = 7,
    parameter int unsigned CYC_W  = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [COST_W-1:0] in_data;
    logic              in_last;
    logic              jam_rst;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic [3:0]        MatchCount;
    logic [9:0]        MinCost;
    logic              Valid;
    logic              res_valid;
    logic              res_ready;
    logic [9:0]        res_min_cost;
    logic [3:0]        res_match_count;
    logic [CYC_W-1:0]  res_cycles;
    logic              res_load_err;
    logic              res_timeout;

    modport slave (
        input  in_valid, in_data, in_last, W, J, MatchCount, MinCost, Valid, res_ready,
        output in_ready, jam_rst, Cost, res_valid, res_min_cost, res_match_count,
               res_cycles, res_load_err, res_timeout
    );

    modport master (
        output in_valid, in_data, in_last, W, J, MatchCount, MinCost, Valid, res_ready,
        input  in_ready, jam_rst, Cost, res_valid, res_min_cost, res_match_count,
               res_cycles, res_load_err, res_timeout
    );
endinterface

// File: rtl/jam_host.sv
// Host front end for JAM: streams in an 8x8 cost table, serves Cost lookups,
// sequences JAM reset and captures the result with a run-cycle count.
module jam_host #(
    parameter int unsigned COST_W  = 7,
    parameter int unsigned CYC_W   = 24,
    parameter int unsigned TIMEOUT = 0
) (
    input logic      CLK,
    input logic      RST_n,
    jam_host_if.slave bus
);
    typedef enum logic [1:0] {LOAD, RUN, RES} state_t;

    localparam logic [CYC_W-1:0] TIMEOUT_V  = CYC_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    state_t            state, state_next;
    logic [5:0]        addr;
    logic [COST_W-1:0] mem [64];
    logic [CYC_W-1:0]  cnt;
    logic              load_err;

    logic              in_ready_q, jam_rst_q, res_valid_q;
    logic [9:0]        res_min_cost_q;
    logic [3:0]        res_match_count_q;
    logic [CYC_W-1:0]  res_cycles_q;
    logic              res_load_err_q, res_timeout_q;

    logic beat, last_beat, timed_out, res_take;
    logic in_ready_d, jam_rst_d, res_valid_d, capture, run_enter;

    assign beat      = (state == LOAD) && bus.in_valid && in_ready_q;
    assign last_beat = beat && (addr == 6'd63);
    assign timed_out = TIMEOUT_EN && (cnt == TIMEOUT_V) && !bus.Valid;
    assign res_take  = (state == RES) && res_valid_q && bus.res_ready;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (last_beat) state_next = RUN;
            RUN:     if (bus.Valid || timed_out) state_next = RES;
            RES:     if (res_take) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // in_ready only rises after a full cycle spent in LOAD, giving the
    // one-edge delay after reset release and after the result handshake.
    always_comb begin
        in_ready_d  = (state == LOAD) && (state_next == LOAD);
        jam_rst_d   = (state_next != RUN);
        res_valid_d = (state_next == RES);
        capture     = (state == RUN) && (state_next == RES);
        run_enter   = (state == LOAD) && (state_next == RUN);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            addr              <= '0;
            cnt               <= '0;
            load_err          <= 1'b0;
            in_ready_q        <= 1'b0;
            jam_rst_q         <= 1'b1;
            res_valid_q       <= 1'b0;
            res_min_cost_q    <= '0;
            res_match_count_q <= '0;
            res_cycles_q      <= '0;
            res_load_err_q    <= 1'b0;
            res_timeout_q     <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            jam_rst_q   <= jam_rst_d;
            res_valid_q <= res_valid_d;

            if (beat) begin
                addr <= addr + 6'd1;
                if (bus.in_last != (addr == 6'd63)) load_err <= 1'b1;
            end else if (res_take) begin
                load_err <= 1'b0;
            end

            if (run_enter)
                cnt <= CYC_W'(1);
            else if (state == RUN && cnt != '1)
                cnt <= cnt + CYC_W'(1);

            if (capture) begin
                res_load_err_q <= load_err;
                if (bus.Valid) begin
                    res_min_cost_q    <= bus.MinCost;
                    res_match_count_q <= bus.MatchCount;
                    res_cycles_q      <= cnt;
                    res_timeout_q     <= 1'b0;
                end else begin
                    res_min_cost_q    <= '1;
                    res_match_count_q <= '0;
                    res_cycles_q      <= TIMEOUT_V;
                    res_timeout_q     <= 1'b1;
                end
            end
        end
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (beat) mem[addr] <= bus.in_data;
    end

    assign bus.Cost            = mem[{bus.W, bus.J}];
    assign bus.in_ready        = in_ready_q;
    assign bus.jam_rst         = jam_rst_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_min_cost    = res_min_cost_q;
    assign bus.res_match_count = res_match_count_q;
    assign bus.res_cycles      = res_cycles_q;
    assign bus.res_load_err    = res_load_err_q;
    assign bus.res_timeout     = res_timeout_q;
endmodule
